// File: rtl/kbd_pkg.sv
// Shared constants and types for the keyboard character front end.
package kbd_pkg;

    // Set-2 make codes
    localparam logic [7:0] CAPS   = 8'h58;
    localparam logic [7:0] LSHIFT = 8'h12;
    localparam logic [7:0] RSHIFT = 8'h59;
    localparam logic [7:0] ENTER  = 8'h5A;
    localparam logic [7:0] BKSP   = 8'h66;
    localparam logic [7:0] SPACE  = 8'h29;

    // ASCII control characters produced by the mapper
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] SP = 8'h20;

    // One captured keyboard event travelling from stage 1 to stage 2
    typedef struct packed {
        logic [8:0] code;       // bit 8 = E0-extended
        logic       press;
        logic       is_repeat;  // same code pressed again with no release in between
        logic       shift;      // Shift level at capture time
    } kbd_event_t;

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational set-2 make code to ASCII lookup.
// Optional feature: define KBD_SHIFT_SYMBOL_EN to turn Shift+digit into the
// US symbol row; otherwise digits ignore Shift.
module scancode_to_ascii
    import kbd_pkg::*;
(
    input  logic [8:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii,
    output logic       hit
);

`ifdef KBD_SHIFT_SYMBOL_EN
    function automatic logic [7:0] shift_symbol(input logic [7:0] digit);
        case (digit)
            8'h31:   shift_symbol = 8'h21; // !
            8'h32:   shift_symbol = 8'h40; // @
            8'h33:   shift_symbol = 8'h23; // #
            8'h34:   shift_symbol = 8'h24; // $
            8'h35:   shift_symbol = 8'h25; // %
            8'h36:   shift_symbol = 8'h5E; // ^
            8'h37:   shift_symbol = 8'h26; // &
            8'h38:   shift_symbol = 8'h2A; // *
            8'h39:   shift_symbol = 8'h28; // (
            default: shift_symbol = 8'h29; // 0 -> )
        endcase
    endfunction
`endif

    logic [7:0] base;   // letters lowercase, digits plain; 0 = no character
    logic       upper;

    assign upper = shift ^ caps;

    // Raw table lookup; only extended Enter is honoured among E0 codes
    always_comb begin
        base = 8'h00;
        if (code == {1'b1, ENTER}) begin
            base = CR;
        end else if (!code[8]) begin
            case (code[7:0])
                8'h1C: base = 8'h61; 8'h32: base = 8'h62; 8'h21: base = 8'h63;
                8'h23: base = 8'h64; 8'h24: base = 8'h65; 8'h2B: base = 8'h66;
                8'h34: base = 8'h67; 8'h33: base = 8'h68; 8'h43: base = 8'h69;
                8'h3B: base = 8'h6A; 8'h42: base = 8'h6B; 8'h4B: base = 8'h6C;
                8'h3A: base = 8'h6D; 8'h31: base = 8'h6E; 8'h44: base = 8'h6F;
                8'h4D: base = 8'h70; 8'h15: base = 8'h71; 8'h2D: base = 8'h72;
                8'h1B: base = 8'h73; 8'h2C: base = 8'h74; 8'h3C: base = 8'h75;
                8'h2A: base = 8'h76; 8'h1D: base = 8'h77; 8'h22: base = 8'h78;
                8'h35: base = 8'h79; 8'h1A: base = 8'h7A;
                8'h45: base = 8'h30; 8'h16: base = 8'h31; 8'h1E: base = 8'h32;
                8'h26: base = 8'h33; 8'h25: base = 8'h34; 8'h2E: base = 8'h35;
                8'h36: base = 8'h36; 8'h3D: base = 8'h37; 8'h3E: base = 8'h38;
                8'h46: base = 8'h39;
                SPACE: base = SP;
                ENTER: base = CR;
                BKSP:  base = BS;
                default: base = 8'h00;
            endcase
        end
    end

    // Case folding for letters and, when enabled, shifted digit symbols
    always_comb begin
        ascii = base;
        hit   = (base != 8'h00);
        if (upper && (base >= 8'h61) && (base <= 8'h7A)) begin
            ascii = base - 8'h20;
        end
`ifdef KBD_SHIFT_SYMBOL_EN
        if (shift && (base >= 8'h30) && (base <= 8'h39)) begin
            ascii = shift_symbol(base);
        end
`endif
    end

endmodule

// File: rtl/kbd_char_fifo.sv
// PS/2 keystroke to ASCII front end with a show-ahead character FIFO.
// Stage 1 captures the key event, stage 2 looks it up and pushes it.
// Optional feature macro: KBD_SHIFT_SYMBOL_EN (handled in scancode_to_ascii).
//
// Output handshake: char_valid is the valid, rd_en is the ready. A character
// is consumed at an edge where char_valid=1 and rd_en=1; char_data holds the
// head steady while char_valid=1 and rd_en=0. rd_en while empty is ignored.
module kbd_char_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int CHAR_W        = 8,
    parameter int ACCEPT_REPEAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [511:0]           key_down,
    input  logic [8:0]             last_change,
    input  logic                   key_valid,
    input  logic                   rd_en,
    output logic [CHAR_W-1:0]      char_data,
    output logic                   char_valid,
    output logic                   fifo_full,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   caps_led,
    output logic                   lower_case
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic              shift_lvl;
    logic              is_press;
    logic              code_match;
    logic              last_vld;
    logic [8:0]        last_code;
    logic              ev_valid;
    kbd_event_t        ev;
    logic [7:0]        ascii;
    logic              hit;
    logic [CHAR_W-1:0] char_in;
    logic              push_req;
    logic              push_ok;
    logic              pop_ok;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CHAR_W-1:0] mem [DEPTH];

    assign shift_lvl  = key_down[{1'b0, LSHIFT}] | key_down[{1'b0, RSHIFT}];
    assign is_press   = key_down[last_change];
    assign code_match = last_vld && (last_code == last_change);

    // Stage 1: capture the event, track repeats, Caps toggle and case level
    always_ff @(posedge clk) begin
        if (!rst) begin
            ev_valid   <= 1'b0;
            ev         <= '0;
            last_vld   <= 1'b0;
            last_code  <= '0;
            caps_led   <= 1'b0;
            lower_case <= 1'b1;
        end else begin
            ev_valid <= key_valid;
            if (key_valid) begin
                ev.code      <= last_change;
                ev.press     <= is_press;
                ev.is_repeat <= is_press && code_match;
                ev.shift     <= shift_lvl;
                if (is_press) begin
                    last_code <= last_change;
                    last_vld  <= 1'b1;
                end else if (code_match) begin
                    last_vld <= 1'b0;
                end
                if (is_press && !code_match && (last_change == {1'b0, CAPS})) begin
                    caps_led <= ~caps_led;
                end
            end
            lower_case <= ~(shift_lvl ^ caps_led);
        end
    end

    scancode_to_ascii u_map (
        .code  (ev.code),
        .shift (ev.shift),
        .caps  (caps_led),
        .ascii (ascii),
        .hit   (hit)
    );

    if (CHAR_W >= 8) begin : g_wide
        assign char_in = CHAR_W'(ascii);
    end else begin : g_narrow
        assign char_in = ascii[CHAR_W-1:0];
    end

    assign push_req   = ev_valid && ev.press && hit && ((ACCEPT_REPEAT != 0) || !ev.is_repeat);
    assign char_valid = (fifo_count != '0);
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign pop_ok     = rd_en && char_valid;
    assign push_ok    = push_req && (!fifo_full || pop_ok);
    assign char_data  = char_valid ? mem[rd_ptr] : '0;

    // Stage 2: pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && !push_ok) overflow <= 1'b1;
        end
    end

    // Character storage; contents beyond the occupancy are never observed
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= char_in;
    end

endmodule
